seg7_scan_display: RTL and testbench



---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_glyph_decoder.sv | 9 +
 rtl/seg7_scan_display.sv | 100 ++++++++++
 tb/tb_seg7_scan_display.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph codes and active-low segment encodings for the scan display
// Segment order is {a,b,c,d,e,f,g}; a cleared bit lights the segment.
package seg7_pkg;
    localparam logic [4:0] GLYPH_P     = 5'd16;
    localparam logic [4:0] GLYPH_D     = 5'd17;
    localparam logic [4:0] GLYPH_R     = 5'd18;
    localparam logic [4:0] GLYPH_L     = 5'd19;
    localparam logic [4:0] GLYPH_F     = 5'd20;
    localparam logic [4:0] GLYPH_B     = 5'd21;
    localparam logic [4:0] GLYPH_MINUS = 5'd22;
    localparam logic [4:0] GLYPH_BLANK = 5'd31;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    function automatic logic [6:0] glyph_to_seg(input logic [4:0] glyph);
        case (glyph)
            5'd0:        return 7'h01;
            5'd1:        return 7'h4F;
            5'd2:        return 7'h12;
            5'd3:        return 7'h06;
            5'd4:        return 7'h4C;
            5'd5:        return 7'h24;
            5'd6:        return 7'h20;
            5'd7:        return 7'h0F;
            5'd8:        return 7'h00;
            5'd9:        return 7'h04;
            5'd10:       return 7'h08;
            5'd11:       return 7'h60;
            5'd12:       return 7'h31;
            5'd13:       return 7'h42;
            5'd14:       return 7'h30;
            5'd15:       return 7'h38;
            GLYPH_P:     return 7'h18;
            GLYPH_D:     return 7'h42;
            GLYPH_R:     return 7'h7A;
            GLYPH_L:     return 7'h71;
            GLYPH_F:     return 7'h38;
            GLYPH_B:     return 7'h60;
            GLYPH_MINUS: return 7'h7E;
            default:     return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/seg7_glyph_decoder.sv
// seg7_glyph_decoder: combinational glyph code to active-low segment pattern
module seg7_glyph_decoder
    import seg7_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [6:0] seg
);
    always_comb seg = glyph_to_seg(glyph);
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed common-anode 7-segment driver with double-buffered frames,
// 16-level PWM brightness and per-digit blink; all pin outputs are registered.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk100mhz,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] frame_data,
    input  logic [NUM_DIGITS-1:0]   frame_dp,
    input  logic [NUM_DIGITS-1:0]   frame_blink,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [3:0]              brightness,
    output logic                    frame_start,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int CW      = $clog2(DIGIT_CYCLES);
    localparam int DW      = $clog2(NUM_DIGITS);
    localparam int BW      = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int SUB_DIV = DIGIT_CYCLES / 16;

    logic [CW-1:0]                   slot_cnt;
    logic [DW-1:0]                   digit_idx;
    logic [BW-1:0]                   blink_cnt;
    logic                            blink_phase;
    logic [NUM_DIGITS-1:0][4:0]      act_glyph, shd_glyph;
    logic [NUM_DIGITS-1:0]           act_dp, act_blink, shd_dp, shd_blink;
    logic                            pending;
    logic                            slot_wrap, frame_end, hidden, pwm_on;
    logic [NUM_DIGITS-1:0]           one_hot;
    logic [6:0]                      glyph_seg;

    seg7_glyph_decoder u_dec (
        .glyph (act_glyph[digit_idx]),
        .seg   (glyph_seg)
    );

    assign frame_ready = ~pending;

    always_comb begin
        one_hot = '0;
        one_hot[digit_idx] = 1'b1;
        slot_wrap = slot_cnt == CW'(DIGIT_CYCLES - 1);
        frame_end = slot_wrap && digit_idx == DW'(NUM_DIGITS - 1);
        hidden = !blink_phase && act_blink[digit_idx];
        // anode is lit while sub = slot_cnt / SUB_DIV is at or below brightness
        pwm_on = 32'(slot_cnt) < (32'(brightness) + 32'd1) * 32'(SUB_DIV);
    end

    always_ff @(posedge clk100mhz or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            act_glyph   <= {NUM_DIGITS{GLYPH_BLANK}};
            act_dp      <= '0;
            act_blink   <= '0;
            shd_glyph   <= {NUM_DIGITS{GLYPH_BLANK}};
            shd_dp      <= '0;
            shd_blink   <= '0;
            pending     <= 1'b0;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= digit_idx == DW'(NUM_DIGITS - 1) ? '0 : digit_idx + 1'b1;
            if (frame_end) begin
                blink_cnt <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
                if (blink_cnt == BW'(BLINK_FRAMES - 1))
                    blink_phase <= ~blink_phase;
            end
            // a capture in the boundary cycle waits for the next boundary
            if (frame_end && pending) begin
                act_glyph <= shd_glyph;
                act_dp    <= shd_dp;
                act_blink <= shd_blink;
                pending   <= 1'b0;
            end else if (frame_valid && !pending) begin
                shd_glyph <= frame_data;
                shd_dp    <= frame_dp;
                shd_blink <= frame_blink;
                pending   <= 1'b1;
            end
            seg         <= hidden ? SEG_BLANK : glyph_seg;
            dp          <= hidden | ~act_dp[digit_idx];
            an          <= pwm_on ? ~one_hot : '1;
            frame_start <= slot_cnt == '0 && digit_idx == '0;
        end
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: random and directed frames checked each cycle against a
// position-based reference model of the scanned display.
module tb_seg7_scan_display;
    localparam int N  = 4;
    localparam int DC = 32;
    localparam int BF = 2;
    localparam int FC = DC * N;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [5*N-1:0] frame_data = '1;
    logic [N-1:0]   frame_dp = '0;
    logic [N-1:0]   frame_blink = '0;
    logic           frame_valid = 1'b0;
    logic           frame_ready;
    logic [3:0]     brightness = 4'd15;
    logic           frame_start;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   an;

    int total = 0;
    int bad = 0;

    seg7_scan_display #(.NUM_DIGITS(N), .DIGIT_CYCLES(DC), .BLINK_FRAMES(BF)) dut (
        .clk100mhz   (clk),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_dp    (frame_dp),
        .frame_blink (frame_blink),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
        .frame_start (frame_start),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    always #5 clk = ~clk;

    // lit segments per glyph code, written as segment letters
    string lit [32] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
                        "abefg", "bcdeg", "eg", "def", "aefg", "cdefg", "g",
                        "", "", "", "", "", "", "", "", ""};

    int         pos;
    logic [4:0] m_glyph [N];
    logic [4:0] s_glyph [N];
    logic [N-1:0] m_dp, m_blink, s_dp, s_blink;
    bit         m_pend, m_took;

    function automatic logic [6:0] ref_seg(input logic [4:0] g);
        string s = lit[g];
        logic [6:0] r = 7'h7F;
        for (int i = 0; i < s.len(); i++) r[6 - (s[i] - "a")] = 1'b0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h pos=%0d", tag, obs, exp, pos);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        m_pend = 0;
        m_dp = '0; m_blink = '0; s_dp = '0; s_blink = '0;
        for (int i = 0; i < N; i++) begin m_glyph[i] = 5'd31; s_glyph[i] = 5'd31; end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_ready", 32'(frame_ready), 32'd1);
    endtask

    // one clock edge: predict outputs from the display position, then advance the model
    task automatic tick();
        int slot = pos % DC;
        int dig = (pos / DC) % N;
        bit vis = ((pos / FC) / BF) % 2 == 0;
        bit show = vis || !m_blink[dig];
        logic [6:0] e_seg = show ? ref_seg(m_glyph[dig]) : 7'h7F;
        logic e_dp = show ? ~m_dp[dig] : 1'b1;
        logic [N-1:0] e_an = (slot / (DC / 16) <= int'(brightness)) ? ~(N'(1) << dig) : '1;
        logic e_fs = pos % FC == 0;
        m_took = 0;
        if (pos % FC == FC - 1 && m_pend) begin
            m_glyph = s_glyph; m_dp = s_dp; m_blink = s_blink; m_pend = 0;
        end else if (frame_valid && !m_pend) begin
            for (int i = 0; i < N; i++) s_glyph[i] = frame_data[5*i +: 5];
            s_dp = frame_dp; s_blink = frame_blink; m_pend = 1; m_took = 1;
        end
        @(posedge clk);
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("an", 32'(an), 32'(e_an));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("frame_ready", 32'(frame_ready), 32'(!m_pend));
        pos++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input logic [5*N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] b);
        int waited = 0;
        frame_data = d; frame_dp = p; frame_blink = b; frame_valid = 1'b1;
        do begin tick(); waited++; end while (!m_took && waited < 3 * FC);
        if (!m_took) chk("offer_timeout", 32'd0, 32'd1);
        frame_valid = 1'b0;
        frame_data = 20'($urandom); frame_dp = 4'($urandom); frame_blink = 4'($urandom);
    endtask

    function automatic logic [5*N-1:0] rand_glyphs();
        logic [5*N-1:0] r;
        for (int i = 0; i < N; i++) r[5*i +: 5] = 5'($urandom_range(0, 31));
        return r;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b0;
        run(300);
        offer({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0100, 4'b0000);
        run(2 * FC);
        brightness = 4'd3;
        run(FC);
        brightness = 4'd0;
        run(FC);
        brightness = 4'd15;
        offer({rand_glyphs()} & 20'hFFFE0 | 20'(5'd16), 4'($urandom), 4'b0001);
        run(6 * FC);
        offer(rand_glyphs(), 4'($urandom), 4'b0000);
        offer(rand_glyphs(), 4'($urandom), 4'($urandom));
        run(3 * FC);
        for (int k = 0; k < 12; k++) begin
            brightness = 4'($urandom_range(0, 15));
            run($urandom_range(0, 150));
            offer(rand_glyphs(), 4'($urandom), 4'($urandom));
        end
        while (pos % FC != FC - 1) tick();
        offer(rand_glyphs(), 4'($urandom), 4'($urandom));
        run(2 * FC);
        offer(rand_glyphs(), 4'($urandom), 4'($urandom));
        run(5);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        model_reset();
        reset = 1'b0;
        brightness = 4'd15;
        run(200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
